// File: rtl/rd_handshake_rx.sv
// Receive side of a 4-phase REQ/ACK crossing: qualifies a quasi-static bus by
// repeated sampling, pulses DATA_VALID on a stable word and returns ACK to the sender.
module rd_handshake_rx #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ERR_WIDTH      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_SYNC,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  DATA_VALID,
    output logic                  ACK,
    output logic                  BUSY,
    output logic                  CAPTURE_ERR,
    output logic                  TIMEOUT_ERR,
    output logic [ERR_WIDTH-1:0]  ERR_COUNT
);

    localparam int unsigned RetryWidth = 4;
    localparam int unsigned TimerWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TimeoutEn  = (TIMEOUT_CYCLES != 0);
    localparam logic [RetryWidth-1:0] RetryMax  = RetryWidth'(MAX_RETRIES);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StAckHi,
        StDrain
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  sample_q, sample_d;
    logic [RetryWidth-1:0]  retry_q, retry_d;
    logic [TimerWidth-1:0]  timer_q, timer_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   valid_q, valid_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   cap_err_q, cap_err_d;
    logic                   tmo_err_q, tmo_err_d;
    logic [ERR_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic                   err_bump;

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ack_d      = ack_q;
        cap_err_d  = 1'b0;
        tmo_err_d  = 1'b0;
        err_cnt_d  = err_cnt_q;
        err_bump   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (REQ_SYNC) begin
                    sample_d = DATA_IN;
                    retry_d  = '0;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                // A request withdrawn before qualification is dropped silently.
                if (!REQ_SYNC) begin
                    state_d = StIdle;
                end else if (DATA_IN == sample_q) begin
                    data_out_d = sample_q;
                    valid_d    = 1'b1;
                    ack_d      = 1'b1;
                    timer_d    = '0;
                    state_d    = StAckHi;
                end else if (retry_q < RetryMax) begin
                    sample_d = DATA_IN;
                    retry_d  = retry_q + 1'b1;
                end else begin
                    // Still acknowledge so the sender is never stalled by a bad bus.
                    cap_err_d = 1'b1;
                    err_bump  = 1'b1;
                    ack_d     = 1'b1;
                    timer_d   = '0;
                    state_d   = StAckHi;
                end
            end
            StAckHi: begin
                if (!REQ_SYNC) begin
                    ack_d   = 1'b0;
                    timer_d = '0;
                    state_d = StIdle;
                end else if (TimeoutEn && (timer_q == TimerLast)) begin
                    tmo_err_d = 1'b1;
                    err_bump  = 1'b1;
                    ack_d     = 1'b0;
                    timer_d   = '0;
                    state_d   = StDrain;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDrain: begin
                if (!REQ_SYNC) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                ack_d   = 1'b0;
            end
        endcase

        if (err_bump && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            sample_q   <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            cap_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            cap_err_q  <= cap_err_d;
            tmo_err_q  <= tmo_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign DATA_OUT    = data_out_q;
    assign DATA_VALID  = valid_q;
    assign ACK         = ack_q;
    assign BUSY        = busy_q;
    assign CAPTURE_ERR = cap_err_q;
    assign TIMEOUT_ERR = tmo_err_q;
    assign ERR_COUNT   = err_cnt_q;

    // Event outputs are single-cycle pulses.
    a_valid_pulse : assert property (@(posedge CLK) disable iff (RST)
        DATA_VALID |=> !DATA_VALID);
    a_cap_err_pulse : assert property (@(posedge CLK) disable iff (RST)
        CAPTURE_ERR |=> !CAPTURE_ERR);
    a_tmo_err_pulse : assert property (@(posedge CLK) disable iff (RST)
        TIMEOUT_ERR |=> !TIMEOUT_ERR);
    a_ack_busy : assert property (@(posedge CLK) disable iff (RST)
        ACK |-> BUSY);

endmodule
